// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device
// by driving the open-drain clock/data lines through output enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [1:0] o_err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 20) ? $clog2(TIMEOUT_CYCLES) : 20;
    localparam int INH_W = ($clog2(INHIBIT_CYCLES + 1) > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_WAIT_IDLE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_parity, w_parity_nxt;
    logic [3:0]         r_bitcnt, w_bitcnt_nxt;
    logic [INH_W-1:0]   r_inh_cnt, w_inh_nxt;
    logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_nxt;
    logic               r_data_oe, w_data_oe_nxt;
    logic               r_done, w_done_nxt;
    logic               r_error, w_error_nxt;
    logic [1:0]         r_err_code, w_err_code_nxt;
    logic               w_fall, w_tmo_hit, w_accept;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    // Ready is held low during the done/error pulse so it rises the cycle after.
    assign o_ready   = (r_state == S_IDLE) & ~r_done & ~r_error;
    assign o_busy    = ~o_ready;
    assign w_accept  = i_valid & o_ready;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_err_code  = r_err_code;
    assign ps2_clk_oe  = (r_state == S_INHIBIT) | (r_state == S_START);
    assign ps2_data_oe = r_data_oe;

    // Two-flop synchronizers on the raw pins plus the clock edge register; idle-high.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // State and datapath registers; reset aborts any frame without a done/error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bitcnt   <= '0;
            r_inh_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_inh_cnt  <= w_inh_nxt;
            r_tmo_cnt  <= w_tmo_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    // Next-state and next-output logic; timeout beats a clock fall in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_bitcnt_nxt   = r_bitcnt;
        w_inh_nxt      = r_inh_cnt;
        w_tmo_nxt      = r_tmo_cnt;
        w_data_oe_nxt  = r_data_oe;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_IDLE: begin
                w_data_oe_nxt = 1'b0;
                if (w_accept) begin
                    w_shift_nxt    = i_data;
                    w_parity_nxt   = ~^i_data;
                    w_bitcnt_nxt   = '0;
                    w_err_code_nxt = 2'b00;
                    w_inh_nxt      = '0;
                    w_state_nxt    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    w_state_nxt   = S_START;
                    w_data_oe_nxt = 1'b1;
                    w_tmo_nxt     = '0;
                end else begin
                    w_inh_nxt = r_inh_cnt + 1'b1;
                end
            end
            S_START, S_SHIFT, S_WAIT_IDLE: begin
                if (w_tmo_hit) begin
                    w_data_oe_nxt  = 1'b0;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = 2'b01;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                    if (r_state == S_START) begin
                        w_state_nxt = S_SHIFT;
                    end else if (r_state == S_SHIFT) begin
                        if (w_fall) begin
                            w_bitcnt_nxt = r_bitcnt + 1'b1;
                            if (r_bitcnt < 4'd8) begin
                                w_data_oe_nxt = ~r_shift[r_bitcnt[2:0]];
                            end else if (r_bitcnt == 4'd8) begin
                                w_data_oe_nxt = ~r_parity;
                            end else if (r_bitcnt == 4'd9) begin
                                w_data_oe_nxt = 1'b0;
                            end else begin
                                w_data_oe_nxt = 1'b0;
                                if (r_dat_s2) begin
                                    w_error_nxt    = 1'b1;
                                    w_err_code_nxt = 2'b10;
                                    w_state_nxt    = S_IDLE;
                                end else begin
                                    w_state_nxt = S_WAIT_IDLE;
                                end
                            end
                        end
                    end else begin
                        w_data_oe_nxt = 1'b0;
                        if (r_clk_s2 & r_dat_s2) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end
endmodule
